bu_iter: RTL and testbench
==========================

// Module: bu_iter
// PURPOSE
//  Multi-cycle, parametrised successor to the combinational branch unit.
//  Resolves BEQ/BNE/BLT/BGE/BLTU/BGEU on DATA_W-bit operands, comparing CHUNK_W bits per cycle, MSB chunk first.
//  Optionally terminates early at the first differing chunk.
//  Sits between operand read and the fetch redirect logic, behind a valid/ready handshake on both sides.
// PARAMETERS
//  DATA_W     32  operand width; must be a multiple of CHUNK_W
//  CHUNK_W    8   bits compared per cycle; CHUNK_W==DATA_W gives a single compare cycle
//  EARLY_EXIT 1   1: finish at the first differing chunk; 0: always run N=DATA_W/CHUNK_W cycles
// PORTS
//  i_clk      in   1       clock, rising edge
//  i_rst      in   1       reset, asynchronous, active-high
//  i_valid    in   1       request valid
//  o_ready    out  1       unit can accept a request (high only in IDLE)
//  i_a        in   DATA_W  operand a
//  i_b        in   DATA_W  operand b
//  i_cmp_op   in   3       compare op, `BU_* encoding
//  o_valid    out  1       result valid
//  i_ready    in   1       consumer takes the result
//  o_taken    out  1       branch taken; meaningful only while o_valid=1
// BEHAVIOUR
//  Reset (async, i_rst=1): state=IDLE, o_valid=0, o_taken=0, o_ready=1, all datapath registers cleared.
//  FSM states and transitions:
//   IDLE -> BUSY when i_valid&o_ready; i_a, i_b and i_cmp_op are latched; chunk index k=N-1.
//   BUSY: each cycle compare a_q[k], b_q[k].
//    Chunk N-1 is the signed chunk: its MSB is inverted for BLT/BGE only. Lower chunks are unsigned.
//    Equal chunk: decrement k.
//    First differing chunk: latch lt=(a_chunk<b_chunk) and set decided=1. Later chunks never overwrite lt.
//    Go to DONE when (EARLY_EXIT && chunk differs) || k==0. All chunks equal: eq=1, lt=0.
//   DONE: o_valid=1 and o_taken is stable; on i_ready -> IDLE next cycle.
//  o_taken values: BEQ=eq, BNE=~eq, BLT/BLTU=lt, BGE/BGEU=~lt. Undefined codes (3'b010, 3'b011) give taken=0.
//  Latency, counted from the accept edge to the first o_valid cycle:
//   EARLY_EXIT=0: exactly N cycles.
//   EARLY_EXIT=1: j cycles, where j is the 1-based position of the first differing chunk from the MSB; N if all chunks equal.
//  Handshake rules:
//   No overlap: o_ready=0 in BUSY and DONE. i_valid is ignored in those states.
//   Operand or op changes after accept have no effect.
//   o_valid/o_taken hold stable under backpressure (i_ready=0) indefinitely.
//   With i_ready=1 in DONE, o_valid is high for exactly one cycle. Earliest next accept is the following cycle.
//  Reset mid-BUSY or mid-DONE: aborts the operation, o_valid drops immediately, and no result is ever emitted.
// STRUCTURE
//  bu.mac.vh holds the shared op encodings (funct3):
//   BU_BEQ=3'b000, BU_BNE=3'b001, BU_BLT=3'b100, BU_BGE=3'b101, BU_BLTU=3'b110, BU_BGEU=3'b111.
//  bu.mac.vh also holds the state encodings BU_ITER_IDLE/BUSY/DONE.
//  One sub-module, bu_chunk_cmp (CHUNK_W, i_signed) -> o_eq, o_lt, purely combinational.
//  Chunk select is a shift of the operand registers by CHUNK_W each BUSY cycle; no wide mux.
// TESTING
//  Default params unless stated; results checked with `assert.
//  1. a=-4, b=10, each op -> BEQ 0, BNE 1, BLT 1, BGE 0, BLTU 0, BGEU 1; latency 1 (top chunk differs).
//  2. a=b=32'h12345678: BEQ -> 1, BLT -> 0, BGE -> 1; latency 4.
//  3. a=32'h105, b=32'h106, BLTU -> 1, latency 4.
//     a=32'h80000000, b=32'h7FFFFFFF: BLT -> 1, BLTU -> 0, latency 1.
//  4. Hold i_ready=0 for 5 cycles in DONE and pulse i_valid -> o_valid/o_taken stable, o_ready=0, request ignored.
//     Then i_ready=1 -> o_ready=1 next cycle.
//  5. Assert i_rst during the 2nd BUSY cycle -> o_valid never rises, o_ready=1; next op (case 1 BNE) -> 1.
//  6. EARLY_EXIT=0 instance: case 1 latency 4. Op 3'b011 -> taken 0.
//     CHUNK_W=32 instance: every op has latency 1.

Source files
------------

// File: rtl/bu_iter_pkg.sv
// Shared definitions for the iterative branch unit: compare-op encodings (funct3),
// FSM state type and small decode helpers.
package bu_iter_pkg;

  localparam logic [2:0] BuBeq  = 3'b000;
  localparam logic [2:0] BuBne  = 3'b001;
  localparam logic [2:0] BuBlt  = 3'b100;
  localparam logic [2:0] BuBge  = 3'b101;
  localparam logic [2:0] BuBltu = 3'b110;
  localparam logic [2:0] BuBgeu = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } bu_iter_state_e;

  function automatic logic bu_op_signed(input logic [2:0] op);
    return (op == BuBlt) || (op == BuBge);
  endfunction

  // decided = some chunk differed; lt = a<b at the first differing chunk.
  function automatic logic bu_taken(input logic [2:0] op, input logic decided, input logic lt);
    logic taken;
    taken = 1'b0;
    case (op)
      BuBeq:          taken = ~decided;
      BuBne:          taken = decided;
      BuBlt, BuBltu:  taken = lt;
      BuBge, BuBgeu:  taken = ~lt;
      default:        taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/bu_chunk_cmp.sv
// Combinational compare of one operand chunk; i_signed flips the MSB of both sides
// so a plain unsigned compare gives the two's-complement ordering.
module bu_chunk_cmp #(
  parameter int unsigned CHUNK_W = 8
) (
  input  logic [CHUNK_W-1:0] i_a,
  input  logic [CHUNK_W-1:0] i_b,
  input  logic               i_signed,
  output logic               o_eq,
  output logic               o_lt
);

  logic [CHUNK_W-1:0] a_x;
  logic [CHUNK_W-1:0] b_x;

  always_comb begin
    a_x              = i_a;
    b_x              = i_b;
    a_x[CHUNK_W-1]   = i_a[CHUNK_W-1] ^ i_signed;
    b_x[CHUNK_W-1]   = i_b[CHUNK_W-1] ^ i_signed;
    o_eq             = (i_a == i_b);
    o_lt             = (a_x < b_x);
  end

endmodule

// File: rtl/bu_iter.sv
// Multi-cycle branch resolver: compares CHUNK_W bits per cycle, MSB chunk first, with an
// optional early exit at the first differing chunk. Valid/ready handshake on both sides.
module bu_iter
  import bu_iter_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CHUNK_W    = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [2:0]        i_cmp_op,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_taken
);

  localparam int unsigned N  = DATA_W / CHUNK_W;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLast = KW'(N - 1);

  bu_iter_state_e    state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic [KW-1:0]     k_q, k_d;
  logic              lt_q, lt_d;
  logic              decided_q, decided_d;

  logic chunk_eq;
  logic chunk_lt;
  logic chunk_signed;

  // Only the top chunk carries the sign bit.
  assign chunk_signed = (k_q == KLast) && bu_op_signed(op_q);

  bu_chunk_cmp #(
    .CHUNK_W (CHUNK_W)
  ) u_chunk_cmp (
    .i_a      (a_q[DATA_W-1 -: CHUNK_W]),
    .i_b      (b_q[DATA_W-1 -: CHUNK_W]),
    .i_signed (chunk_signed),
    .o_eq     (chunk_eq),
    .o_lt     (chunk_lt)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    k_d       = k_q;
    lt_d      = lt_q;
    decided_d = decided_q;
    o_ready   = 1'b0;
    o_valid   = 1'b0;

    unique case (state_q)
      StIdle: begin
        o_ready = 1'b1;
        if (i_valid) begin
          a_d       = i_a;
          b_d       = i_b;
          op_d      = i_cmp_op;
          k_d       = KLast;
          lt_d      = 1'b0;
          decided_d = 1'b0;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        // Shift the next chunk into the top slot instead of muxing by index.
        a_d = a_q << CHUNK_W;
        b_d = b_q << CHUNK_W;
        k_d = k_q - KW'(1);
        if (!chunk_eq && !decided_q) begin
          lt_d      = chunk_lt;
          decided_d = 1'b1;
        end
        if ((EARLY_EXIT && !chunk_eq) || (k_q == '0)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        o_valid = 1'b1;
        if (i_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign o_taken = (state_q == StDone) & bu_taken(op_q, decided_q, lt_q);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      k_q       <= '0;
      lt_q      <= 1'b0;
      decided_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      k_q       <= k_d;
      lt_q      <= lt_d;
      decided_q <= decided_d;
    end
  end

endmodule

// File: tb/tb_bu_iter.sv
// Directed bench for bu_iter: default, no-early-exit and single-chunk instances.
module tb_bu_iter;

  logic        clk;
  logic        rst;
  logic [31:0] ia;
  logic [31:0] ib;
  logic [2:0]  iop;
  logic        irdy;
  logic [2:0]  vin;
  logic [2:0]  rdyo;
  logic [2:0]  vld;
  logic [2:0]  tkn;

  int checks;
  int errors;

  localparam int D  = 0;  // default instance
  localparam int NE = 1;  // EARLY_EXIT=0
  localparam int W  = 2;  // CHUNK_W=32

  bu_iter u_dut (
    .i_clk (clk), .i_rst (rst), .i_valid (vin[D]), .o_ready (rdyo[D]),
    .i_a (ia), .i_b (ib), .i_cmp_op (iop), .o_valid (vld[D]), .i_ready (irdy),
    .o_taken (tkn[D])
  );

  bu_iter #(.EARLY_EXIT(1'b0)) u_dut_ne (
    .i_clk (clk), .i_rst (rst), .i_valid (vin[NE]), .o_ready (rdyo[NE]),
    .i_a (ia), .i_b (ib), .i_cmp_op (iop), .o_valid (vld[NE]), .i_ready (irdy),
    .o_taken (tkn[NE])
  );

  bu_iter #(.CHUNK_W(32)) u_dut_w (
    .i_clk (clk), .i_rst (rst), .i_valid (vin[W]), .o_ready (rdyo[W]),
    .i_a (ia), .i_b (ib), .i_cmp_op (iop), .o_valid (vld[W]), .i_ready (irdy),
    .o_taken (tkn[W])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One request on instance idx; inputs are scrambled right after accept.
  task automatic run(input int idx, input logic [31:0] a, input logic [31:0] b,
                     input logic [2:0] op, input logic exp_t, input int exp_lat,
                     input string tag, input bit hold);
    int lat;
    lat = 0;
    @(negedge clk);
    ia = a; ib = b; iop = op; vin[idx] = 1'b1;
    chk({tag, " o_ready"}, 32'(rdyo[idx]), 32'd1);
    @(posedge clk); #1;
    vin[idx] = 1'b0; ia = ~a; ib = a; iop = ~op;
    while (lat < 20 && vld[idx] !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " o_valid"}, 32'(vld[idx]), 32'd1);
    chk({tag, " o_taken"}, 32'(tkn[idx]), 32'(exp_t));
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    if (!hold) begin
      @(posedge clk); #1;
      chk({tag, " o_valid one cycle"}, 32'(vld[idx]), 32'd0);
      chk({tag, " o_ready after"}, 32'(rdyo[idx]), 32'd1);
    end
  endtask

  initial begin
    logic [2:0] ops [6];
    logic       exp1 [6];
    checks = 0; errors = 0;
    rst = 1'b1; vin = '0; irdy = 1'b1; ia = '0; ib = '0; iop = '0;
    ops  = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    exp1 = '{1'b0,   1'b1,   1'b1,   1'b0,   1'b0,   1'b1};

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset o_ready", 32'(rdyo[i]), 32'd1);
      chk("reset o_valid", 32'(vld[i]), 32'd0);
      chk("reset o_taken", 32'(tkn[i]), 32'd0);
    end
    @(negedge clk); rst = 1'b0;

    // 1: a=-4, b=10, every op, top chunk differs
    for (int i = 0; i < 6; i++)
      run(D, 32'hFFFF_FFFC, 32'd10, ops[i], exp1[i], 1, $sformatf("c1 op%0d", ops[i]), 1'b0);

    // 2: equal operands
    run(D, 32'h1234_5678, 32'h1234_5678, 3'b000, 1'b1, 4, "c2 beq", 1'b0);
    run(D, 32'h1234_5678, 32'h1234_5678, 3'b100, 1'b0, 4, "c2 blt", 1'b0);
    run(D, 32'h1234_5678, 32'h1234_5678, 3'b101, 1'b1, 4, "c2 bge", 1'b0);

    // 3: low-chunk difference and signed/unsigned top-chunk boundary
    run(D, 32'h0000_0105, 32'h0000_0106, 3'b110, 1'b1, 4, "c3 bltu lo", 1'b0);
    run(D, 32'h8000_0000, 32'h7FFF_FFFF, 3'b100, 1'b1, 1, "c3 blt min", 1'b0);
    run(D, 32'h8000_0000, 32'h7FFF_FFFF, 3'b110, 1'b0, 1, "c3 bltu min", 1'b0);
    run(D, 32'hFFFF_FFFC, 32'd10, 3'b010, 1'b0, 1, "c3 undef010", 1'b0);

    // 4: backpressure in DONE, new requests ignored
    irdy = 1'b0;
    run(D, 32'hFFFF_FFFC, 32'd10, 3'b100, 1'b1, 1, "c4 blt", 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vin[D] = 1'b1; ia = 32'd1; ib = 32'd2; iop = 3'b000;
      @(posedge clk); #1;
      vin[D] = 1'b0;
      chk("c4 hold o_valid", 32'(vld[D]), 32'd1);
      chk("c4 hold o_taken", 32'(tkn[D]), 32'd1);
      chk("c4 hold o_ready", 32'(rdyo[D]), 32'd0);
    end
    @(negedge clk); irdy = 1'b1;
    @(posedge clk); #1;
    chk("c4 release o_valid", 32'(vld[D]), 32'd0);
    chk("c4 release o_ready", 32'(rdyo[D]), 32'd1);
    @(posedge clk); #1;
    chk("c4 ignored req o_ready", 32'(rdyo[D]), 32'd1);
    chk("c4 ignored req o_valid", 32'(vld[D]), 32'd0);

    // 5: reset during the 2nd BUSY cycle
    @(negedge clk);
    ia = 32'h1234_5678; ib = 32'h1234_5678; iop = 3'b000; vin[D] = 1'b1;
    @(posedge clk); #1;
    vin[D] = 1'b0;
    @(posedge clk); #1;
    chk("c5 busy o_ready", 32'(rdyo[D]), 32'd0);
    rst = 1'b1;
    #1;
    chk("c5 rst o_valid", 32'(vld[D]), 32'd0);
    chk("c5 rst o_ready", 32'(rdyo[D]), 32'd1);
    @(negedge clk); rst = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (8) begin
        @(posedge clk); #1;
        if (vld[D] === 1'b1) seen++;
      end
      chk("c5 no result after abort", 32'(seen), 32'd0);
    end
    run(D, 32'hFFFF_FFFC, 32'd10, 3'b001, 1'b1, 1, "c5 bne after rst", 1'b0);

    // 6: no early exit; lower chunks must not overwrite the top-chunk decision
    run(NE, 32'hFFFF_FFFC, 32'd10, 3'b100, 1'b1, 4, "c6 ne blt", 1'b0);
    run(NE, 32'hFFFF_FFFC, 32'd10, 3'b111, 1'b1, 4, "c6 ne bgeu", 1'b0);
    run(NE, 32'hFFFF_FFFC, 32'd10, 3'b011, 1'b0, 4, "c6 ne undef011", 1'b0);

    // 6: single-chunk instance
    for (int i = 0; i < 6; i++)
      run(W, 32'hFFFF_FFFC, 32'd10, ops[i], exp1[i], 1, $sformatf("c6 w op%0d", ops[i]), 1'b0);
    run(W, 32'h1234_5678, 32'h1234_5678, 3'b000, 1'b1, 1, "c6 w beq eq", 1'b0);
    run(W, 32'h8000_0000, 32'h7FFF_FFFF, 3'b100, 1'b1, 1, "c6 w blt min", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
